// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: instruction-fetch front end. It keeps one request outstanding to
// instruction memory and buffers the returned {pc, instr} pairs in a first-word-fall-through
// FIFO for the decode stage.
// Latency: an ack in cycle N gives id_valid in N+1, and the next request is already up in N+1.
// With single-cycle memory this sustains one instruction per cycle.
// Backpressure: decode stalls with id_ready=0. Fetch parks in IDLE while the FIFO is full, so
// a push can never overflow it.
// Ports: clk/reset (synchronous, active-high); imem_req/imem_addr/imem_ack/imem_rdata form
// the memory handshake; redirect_valid/redirect_pc carry the execute-stage flush;
// id_valid/id_ready/id_instr/id_pc form the decode handshake; fifo_count gives occupancy;
// misalign_err is the sticky misaligned-redirect flag.
// Optional feature macro: FETCH_ALIGN_CHECK_EN. When defined, redirect targets are forced to
// word alignment and misaligned targets set misalign_err.
module fetch_prefetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic                   imem_ack,
  input  logic [DATA_W-1:0]      imem_rdata,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [DATA_W-1:0]      id_instr,
  output logic [ADDR_W-1:0]      id_pc,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   misalign_err
);

  localparam int                PW   = $clog2(DEPTH);
  localparam int                CW   = PW + 1;
  localparam logic [CW-1:0]     FULL = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] tgt;

  logic [DATA_W-1:0] instr_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_after;
  logic              push, pop, flush;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;

  // Low address bits are dropped so fetch always restarts on a word boundary.
  assign tgt = {redirect_pc[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign_err = misalign_q;
`else
  assign tgt          = redirect_pc;
  assign misalign_err = 1'b0;
`endif

  assign pop         = id_valid && id_ready;
  // Occupancy once this cycle's push and pop have both landed.
  assign count_after = count_q + CW'(1) - CW'(pop);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic, including the fetch-address bookkeeping
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    push    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_d    = tgt;
          addr_d  = tgt;
          state_d = S_WAIT;
        end else if (count_q < FULL) begin
          addr_d  = pc_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            // The returned word belongs to the wrong path, so it is dropped.
            flush   = 1'b1;
            pc_d    = tgt;
            addr_d  = tgt;
            state_d = S_WAIT;
          end else begin
            push    = 1'b1;
            pc_d    = addr_q + STEP;
            addr_d  = addr_q + STEP;
            state_d = (count_after < FULL) ? S_WAIT : S_IDLE;
          end
        end else if (redirect_valid) begin
          // The request cannot be withdrawn. Let it finish at the stale address and
          // throw its data away.
          flush   = 1'b1;
          pc_d    = tgt;
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (redirect_valid) begin
          pc_d = tgt;
        end
        if (imem_ack) begin
          addr_d  = redirect_valid ? tgt : pc_q;
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    imem_req = (state_q != S_IDLE);
  end

  assign imem_addr = addr_q;

  // Prefetch FIFO. A flush takes priority over any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        instr_mem_q[wr_ptr_q] <= imem_rdata;
        pc_mem_q[wr_ptr_q]    <= addr_q;
        wr_ptr_q              <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // The head is read straight from storage. It only moves on a pop, on a write into an
  // empty FIFO, or on a flush.
  assign id_valid   = (count_q != '0);
  assign id_instr   = instr_mem_q[rd_ptr_q];
  assign id_pc      = pc_mem_q[rd_ptr_q];
  assign fifo_count = count_q;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
module tb_fetch_prefetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;
  logic [2:0]  fifo_count;
  logic        misalign_err;

  // Second instance, used for the PC-wrap case
  logic        imem_req2, imem_ack2;
  logic [31:0] imem_addr2, imem_rdata2;
  logic        id_valid2;
  logic [31:0] id_instr2, id_pc2;
  logic [2:0]  fifo_count2;
  logic        misalign_err2;
  logic        redir_zero;
  logic [31:0] redir_pc_zero;
  logic        ready_one;

  fetch_prefetch_unit u_dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .fifo_count(fifo_count), .misalign_err(misalign_err)
  );

  fetch_prefetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
    .redirect_valid(redir_zero), .redirect_pc(redir_pc_zero),
    .id_valid(id_valid2), .id_ready(ready_one), .id_instr(id_instr2), .id_pc(id_pc2),
    .fifo_count(fifo_count2), .misalign_err(misalign_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic [2:0]  cnt;
    logic        vld;
    logic        chkp;
    logic [31:0] pc;
  } vec_t;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  logic        auto_mem;
  int          mem_lat;
  int          wait_cnt;
  logic        popped;
  logic [31:0] sb[$];
  logic [31:0] got2[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input logic ack, input logic rdy, input logic req,
                              input logic [31:0] addr, input logic [2:0] cnt,
                              input logic vld, input logic chkp, input logic [31:0] pc);
    vec_t v;
    v.ack = ack; v.rdy = rdy; v.req = req; v.addr = addr;
    v.cnt = cnt; v.vld = vld; v.chkp = chkp; v.pc = pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive this cycle's inputs on the falling edge, answer as instruction
  // memory, and score any instruction that decode takes this cycle.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc, input logic ack_in);
    logic [31:0] e;
    @(negedge clk);
    cyc++;
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (auto_mem) begin
      if (imem_req && wait_cnt >= mem_lat) begin
        imem_ack = 1'b1;
        wait_cnt = 0;
      end else begin
        imem_ack = 1'b0;
        wait_cnt = imem_req ? wait_cnt + 1 : 0;
      end
    end else begin
      imem_ack = ack_in;
    end
    imem_rdata  = word_of(imem_addr);
    imem_ack2   = imem_req2;
    imem_rdata2 = word_of(imem_addr2);
    popped = 1'b0;
    if (!reset && id_valid && id_ready && !redirect_valid) begin
      popped = 1'b1;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h, required no delivery (cycle %0d)", id_pc, cyc);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", id_pc, e);
        chk("sb_instr", id_instr, word_of(e));
      end
    end
    if (!reset && id_valid2 && got2.size() < 3) got2.push_back(id_pc2);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    auto_mem = 1'b0;
    wait_cnt = 0;
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst_req",      32'(imem_req), 32'h0);
    chk("rst_addr",     imem_addr, 32'h0);
    chk("rst_valid",    32'(id_valid), 32'h0);
    chk("rst_instr",    id_instr, 32'h0);
    chk("rst_pc",       id_pc, 32'h0);
    chk("rst_count",    32'(fifo_count), 32'h0);
    chk("rst_misalign", 32'(misalign_err), 32'h0);
    chk("rst_wrap_addr", imem_addr2, 32'hFFFF_FFF8);
    reset = 1'b0;
    sb.delete();
    got2.delete();
  endtask

  initial begin
    vec_t        tbl[14];
    logic [31:0] exp_wrap[3];
    int          first, last, maxc;
    logic        seen;
    logic [31:0] exp_addr;
    logic        exp_mis;

    // Backpressure sequence. Each row holds the inputs for one cycle and the outputs
    // expected during that cycle. Row 0 is the first cycle after reset is released.
    tbl[0]  = mk(1, 0, 1, 32'h00, 3'd0, 0, 1, 32'h00);
    tbl[1]  = mk(1, 0, 1, 32'h04, 3'd1, 1, 1, 32'h00);
    tbl[2]  = mk(1, 0, 1, 32'h08, 3'd2, 1, 1, 32'h00);
    tbl[3]  = mk(1, 0, 1, 32'h0C, 3'd3, 1, 1, 32'h00);
    tbl[4]  = mk(0, 0, 0, 32'h10, 3'd4, 1, 1, 32'h00);
    tbl[5]  = mk(0, 1, 0, 32'h10, 3'd4, 1, 1, 32'h00);
    tbl[6]  = mk(0, 0, 0, 32'h10, 3'd3, 1, 1, 32'h04);
    tbl[7]  = mk(1, 0, 1, 32'h10, 3'd3, 1, 1, 32'h04);
    tbl[8]  = mk(0, 1, 0, 32'h14, 3'd4, 1, 1, 32'h04);
    tbl[9]  = mk(0, 1, 0, 32'h14, 3'd3, 1, 1, 32'h08);
    tbl[10] = mk(1, 1, 1, 32'h14, 3'd2, 1, 1, 32'h0C);
    tbl[11] = mk(0, 1, 1, 32'h18, 3'd2, 1, 1, 32'h10);
    tbl[12] = mk(0, 1, 1, 32'h18, 3'd1, 1, 1, 32'h14);
    tbl[13] = mk(0, 0, 1, 32'h18, 3'd0, 0, 0, 32'h00);
    exp_wrap[0] = 32'hFFFF_FFF8;
    exp_wrap[1] = 32'hFFFF_FFFC;
    exp_wrap[2] = 32'h0000_0000;

    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; redirect_valid = 1'b0;
    redirect_pc = '0; id_ready = 1'b0; imem_ack2 = 1'b0; imem_rdata2 = '0;
    redir_zero = 1'b0; redir_pc_zero = '0; ready_one = 1'b1;
    auto_mem = 1'b0; mem_lat = 0; wait_cnt = 0;

    // Fill to DEPTH under stall, then drain. No instruction may be lost or repeated.
    do_reset();
    for (int k = 0; k < 6; k++) sb.push_back(32'(k * 4));
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rdy, 1'b0, 32'h0, tbl[i].ack);
      chk($sformatf("bp_r%0d_req", i),   32'(imem_req),   32'(tbl[i].req));
      chk($sformatf("bp_r%0d_addr", i),  imem_addr,       tbl[i].addr);
      chk($sformatf("bp_r%0d_count", i), 32'(fifo_count), 32'(tbl[i].cnt));
      chk($sformatf("bp_r%0d_valid", i), 32'(id_valid),   32'(tbl[i].vld));
      if (tbl[i].chkp) chk($sformatf("bp_r%0d_idpc", i), id_pc, tbl[i].pc);
    end
    chk("bp_all_delivered", 32'(sb.size()), 32'h0);

    // Streaming with single-cycle memory: back-to-back delivery, occupancy never above 1.
    do_reset();
    auto_mem = 1'b1;
    mem_lat  = 0;
    for (int k = 0; k < 8; k++) sb.push_back(32'(k * 4));
    first = -1; last = -1; maxc = 0;
    for (int i = 0; i < 40 && sb.size() > 0; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0);
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      if (popped) begin
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    chk("stream_drained", 32'(sb.size()), 32'h0);
    chk("stream_back_to_back", 32'(last - first), 32'd7);
    chk("stream_max_count", 32'(maxc), 32'd1);

    // The second instance ran alongside with immediate acks and must wrap its PC through zero.
    chk("wrap_count", 32'(got2.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("wrap_pc%0d", i), (i < got2.size()) ? got2[i] : 32'hDEAD_DEAD, exp_wrap[i]);

    // A redirect while a slow request is outstanding. The stale word must be discarded.
    do_reset();
    auto_mem = 1'b1;
    mem_lat  = 3;
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("slow_req_up", 32'(imem_req), 32'h1);
    step(1'b1, 1'b1, 32'h100, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("slow_discard_req", 32'(imem_req), 32'h1);
    chk("slow_stale_addr", imem_addr, 32'h0);
    chk("slow_flushed", 32'(id_valid), 32'h0);
    sb.push_back(32'h100);
    sb.push_back(32'h104);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0);
      if (imem_req && imem_addr != 32'h0) begin
        seen = 1'b1;
        chk("slow_next_addr", imem_addr, 32'h100);
      end
    end
    chk("slow_new_req_seen", 32'(seen), 32'h1);
    for (int i = 0; i < 40 && sb.size() > 0; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("slow_drained", 32'(sb.size()), 32'h0);

    // Redirect in the same cycle as an ack and a pop, with two entries buffered.
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h200, 1'b1);
    chk("same_pre_count", 32'(fifo_count), 32'd2);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("same_count", 32'(fifo_count), 32'h0);
    chk("same_valid", 32'(id_valid), 32'h0);
    chk("same_req", 32'(imem_req), 32'h1);
    chk("same_addr", imem_addr, 32'h200);
    sb.push_back(32'h200);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("same_drained", 32'(sb.size()), 32'h0);

    // Misaligned redirect target
`ifdef FETCH_ALIGN_CHECK_EN
    exp_addr = 32'h100;
    exp_mis  = 1'b1;
`else
    exp_addr = 32'h102;
    exp_mis  = 1'b0;
`endif
    do_reset();
    step(1'b0, 1'b1, 32'h102, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("mis_req", 32'(imem_req), 32'h1);
    chk("mis_addr", imem_addr, exp_addr);
    chk("mis_flag", 32'(misalign_err), 32'(exp_mis));
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("mis_head_pc", id_pc, exp_addr);
    chk("mis_head_instr", id_instr, word_of(exp_addr));
    chk("mis_flag_sticky", 32'(misalign_err), 32'(exp_mis));

    // The flag clears only on reset; do_reset re-checks every reset value.
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
